// File: rtl/arb_mem_dados_pkg.sv
// Shared definitions for the two-requester data-memory arbiter: state encodings, memory size, counter width.
package arb_mem_dados_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  localparam int MEM_PALAVRAS = 64;
  localparam int ACESSOS_W    = 16;

  function automatic logic em_faixa(input logic [31:0] addr);
    return addr < 32'(MEM_PALAVRAS);
  endfunction

endpackage

// File: rtl/arb_mem_dados_arb_rr2.sv
// Two-way round-robin pick; combinational winner, pointer moves only when the grant is taken.
// Latency 0 for the pick; no backpressure, the caller decides when to consume via update.
module arb_rr2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic vencedor
);

  logic ultimo;

  always_comb begin
    vencedor = 1'b0;
    if (req0 && req1) begin
      vencedor = ~ultimo;
    end else if (req1) begin
      vencedor = 1'b1;
    end
  end

  // Reset as "last = 1" so requester 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ultimo <= 1'b1;
    end else if (update) begin
      ultimo <= vencedor;
    end
  end

endmodule

// File: rtl/arb_mem_dados.sv
// Arbitrates CPU and debug ports onto one data memory; grant +1, access +2, response +3 cycles.
// No backpressure: requests are only sampled in OCIOSO, so one access completes every 3 cycles at best.
module arb_mem_dados
  import arb_mem_dados_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [31:0]          addr0,
  input  logic [31:0]          addr1,
  input  logic [31:0]          wdata0,
  input  logic [31:0]          wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [31:0]          rdata,
  output logic                 err_addr,
  output logic                 mem_write,
  output logic                 mem_read,
  output logic [31:0]          mem_pos,
  output logic [31:0]          mem_dados,
  input  logic [31:0]          mem_saida,
  output logic [ACESSOS_W-1:0] acessos
);

  estado_t     estado, prox;
  logic        concede;
  logic        vencedor;
  logic        we_sel;
  logic [31:0] addr_sel;
  logic [31:0] wdata_sel;
  logic        faixa_sel;
  logic        op_we;
  logic        op_ok;
  logic        op_win;

  arb_rr2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .update   (concede),
    .vencedor (vencedor)
  );

  assign we_sel    = vencedor ? we1    : we0;
  assign addr_sel  = vencedor ? addr1  : addr0;
  assign wdata_sel = vencedor ? wdata1 : wdata0;
  assign faixa_sel = em_faixa(addr_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox;
    end
  end

  always_comb begin
    prox    = estado;
    concede = 1'b0;
    case (estado)
      OCIOSO: begin
        if (req0 || req1) begin
          concede = 1'b1;
          prox    = ACESSO;
        end
      end
      ACESSO:   prox = RESPOSTA;
      RESPOSTA: prox = OCIOSO;
      default:  prox = OCIOSO;
    endcase
  end

  // Strobes are registered at grant so they are high exactly during ACESSO; an async
  // reset inside ACESSO drops mem_write before the committing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata     <= '0;
      err_addr  <= 1'b0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_pos   <= '0;
      mem_dados <= '0;
      acessos   <= '0;
      op_we     <= 1'b0;
      op_ok     <= 1'b0;
      op_win    <= 1'b0;
    end else begin
      gnt0      <= concede && !vencedor;
      gnt1      <= concede && vencedor;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      err_addr  <= 1'b0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      if (concede) begin
        op_we     <= we_sel;
        op_ok     <= faixa_sel;
        op_win    <= vencedor;
        mem_pos   <= addr_sel;
        mem_dados <= wdata_sel;
        mem_write <= we_sel && faixa_sel;
        mem_read  <= !we_sel && faixa_sel;
      end
      if (estado == ACESSO) begin
        err_addr <= !op_ok;
        if (!op_we) begin
          rdata   <= op_ok ? mem_saida : 32'h0;
          rvalid0 <= !op_win;
          rvalid1 <= op_win;
        end
        if (op_ok) begin
          acessos <= acessos + ACESSOS_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_arb_mem_dados.sv
// Directed bench for arb_mem_dados with a behavioural 64-word memory and a response scoreboard.
module tb_arb_mem_dados;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0  = 1'b0;
  logic        req1  = 1'b0;
  logic        we0   = 1'b0;
  logic        we1   = 1'b0;
  logic [31:0] addr0 = 32'h0;
  logic [31:0] addr1 = 32'h0;
  logic [31:0] wdata0 = 32'h0;
  logic [31:0] wdata1 = 32'h0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err_addr, mem_write, mem_read;
  logic [31:0] rdata, mem_pos, mem_dados, mem_saida;
  logic [15:0] acessos;

  logic [31:0] mem    [0:63];
  logic [31:0] shadow [0:63];

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } resp_t;

  resp_t resp_q[$];
  logic  win_q[$];
  int    checks = 0;
  int    errors = 0;
  logic [15:0] acc_model = 16'h0;
  logic        last_model = 1'b1;

  arb_mem_dados dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .err_addr  (err_addr),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_pos   (mem_pos),
    .mem_dados (mem_dados),
    .mem_saida (mem_saida),
    .acessos   (acessos)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_pos[5:0]] <= mem_dados;
  end
  assign mem_saida = mem[mem_pos[5:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk(tag, 32'({gnt0, gnt1, rvalid0, rvalid1, err_addr, mem_write, mem_read}), 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_mem_pos"}, mem_pos, 32'h0);
    chk({tag, "_mem_dados"}, mem_dados, 32'h0);
    chk({tag, "_acessos"}, 32'(acessos), 32'h0);
  endtask

  task automatic check_resp();
    resp_t r;
    chk("resp_q_size", 32'(resp_q.size()), 32'd1);
    if (resp_q.size() != 0) begin
      r = resp_q.pop_front();
      chk("rdata", rdata, r.data);
      chk1("rvalid_port", rvalid1, r.port);
    end
  endtask

  // Single access from idle: drive, then check grant, memory strobes and response cycle by cycle.
  task automatic access(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd);
    logic  ok;
    resp_t r;
    ok = addr < 32'd64;
    @(negedge clk);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
    end
    r.port = port;
    r.data = ok ? shadow[addr[5:0]] : 32'h0;
    if (!we) resp_q.push_back(r);
    if (we && ok) shadow[addr[5:0]] = wd;
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    chk1("gnt0", gnt0, !port);
    chk1("gnt1", gnt1, port);
    chk1("mem_write", mem_write, we && ok);
    chk1("mem_read", mem_read, !we && ok);
    if (ok) chk("mem_pos", mem_pos, addr);
    if (we && ok) chk("mem_dados", mem_dados, wd);
    last_model = port;
    if (ok) acc_model++;
    @(negedge clk);
    chk1("err_addr", err_addr, !ok);
    chk1("rvalid0", rvalid0, !we && !port);
    chk1("rvalid1", rvalid1, !we && port);
    if (rvalid0 || rvalid1) check_resp();
    chk("acessos", 32'(acessos), 32'(acc_model));
    @(negedge clk);
    chk("idle_strobes", 32'({gnt0, gnt1, rvalid0, rvalid1, mem_write, mem_read, err_addr}), 32'h0);
  endtask

  // Requests held high continuously: reads of word 5 (port 0) and word 3 (port 1).
  task automatic run_held(input logic r0, input logic r1, input int n);
    int    last_c;
    int    seen;
    logic  w;
    resp_t r;
    we0 = 1'b0; we1 = 1'b0; addr0 = 32'd5; addr1 = 32'd3;
    @(negedge clk);
    req0 = r0;
    req1 = r1;
    for (int i = 0; i < n; i++) begin
      w = (r0 && r1) ? !last_model : r1;
      last_model = w;
      win_q.push_back(w);
    end
    last_c = -3;
    seen   = 0;
    for (int c = 0; c < 3 * n - 1; c++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        chk1("gnt_onehot", gnt0 && gnt1, 1'b0);
        chk("gnt_gap", 32'(c - last_c), 32'd3);
        last_c = c;
        seen++;
        if (win_q.size() != 0) begin
          w = win_q.pop_front();
          chk1("gnt_port", gnt1, w);
          r.port = w;
          r.data = w ? shadow[3] : shadow[5];
          resp_q.push_back(r);
          acc_model++;
        end
      end
      if (rvalid0 || rvalid1) check_resp();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("grant_count", 32'(seen), 32'(n));
    chk("win_q_left", 32'(win_q.size()), 32'd0);
    @(negedge clk);
    chk("held_acessos", 32'(acessos), 32'(acc_model));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    access(1'b0, 1'b1, 32'd5, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd5, 32'h0);
    access(1'b0, 1'b1, 32'd3, 32'hA5A5A5A5);
    access(1'b0, 1'b0, 32'd64, 32'h0);
    access(1'b1, 1'b1, 32'd70, 32'h55AA55AA);

    // Reset lands inside ACESSO of a port-1 write to word 3.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd3; wdata1 = 32'h12345678;
    @(negedge clk);
    req1 = 1'b0;
    chk1("rst_gnt1", gnt1, 1'b1);
    chk1("rst_mem_write", mem_write, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    acc_model  = 16'h0;
    last_model = 1'b1;
    resp_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("mem3_kept", mem[3], shadow[3]);
    rst_n = 1'b1;

    run_held(1'b1, 1'b1, 4);
    run_held(1'b0, 1'b1, 3);

    @(negedge clk);
    force dut.acessos = 16'hFFFE;
    @(negedge clk);
    release dut.acessos;
    acc_model = 16'hFFFE;
    access(1'b0, 1'b1, 32'd10, 32'hCAFEF00D);
    access(1'b1, 1'b0, 32'd10, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_mem_dados.md
ARB_MEM_DADOS -- requirements
Module: arb_mem_dados

Interface
REQ-001 clk  input  1  system clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 req0, req1  input  1 each  access request from requester 0 (CPU load/store) and requester 1 (debug/loader).
REQ-004 we0, we1  input  1 each  1 = write, 0 = read; valid while reqN is high.
REQ-005 addr0, addr1  input  32 each  word address; valid while reqN is high.
REQ-006 wdata0, wdata1  input  32 each  write data; valid while reqN is high.
REQ-007 gnt0, gnt1  output  1 each  registered grant pulse for requester 0 / 1.
REQ-008 rvalid0, rvalid1  output  1 each  registered read-data-valid pulse for requester 0 / 1.
REQ-009 rdata  output  32  read data shared by both requesters; qualified by rvalidN.
REQ-010 err_addr  output  1  one-cycle pulse when an out-of-range access is dropped.
REQ-011 mem_write, mem_read  output  1 each  data-memory write and read strobes.
REQ-012 mem_pos  output  32  data-memory word address.
REQ-013 mem_dados  output  32  data-memory write data.
REQ-014 mem_saida  input  32  data-memory combinational read data.
REQ-015 acessos  output  16  count of completed in-range accesses.

Function
REQ-016 FSM states: OCIOSO, ACESSO, RESPOSTA.
REQ-017 OCIOSO sampling: req0 and req1 are sampled only in OCIOSO.
REQ-018 OCIOSO with any request: on the clock edge, winner's we/addr/wdata are latched, gntN = 1 for exactly one cycle, next state = ACESSO.
REQ-019 OCIOSO with no request: stay in OCIOSO; all strobes stay 0.
REQ-020 ACESSO drive: mem_pos and mem_dados come from the latched values; exactly one of mem_write/mem_read is 1.
REQ-021 ACESSO exit: the clock edge ending ACESSO commits a write, or captures mem_saida into rdata for a read; next state = RESPOSTA.
REQ-022 RESPOSTA (read): rvalidN of the winner = 1 for exactly one cycle.
REQ-023 RESPOSTA (write): no rvalid is asserted.
REQ-024 RESPOSTA exit: next state = OCIOSO unconditionally.
REQ-025 Latency: request sampled at edge E, gnt high in E..E+1, memory access in E+1..E+2, rvalid high in E+2..E+3; one access per 3 cycles minimum.
REQ-026 Requester obligation: each requester drops reqN no later than the end of the RESPOSTA cycle; a req still high in the next OCIOSO is a new request.
REQ-027 Arbitration: round-robin over 2 requesters. A sole requester always wins. On a tie, the requester not granted last wins. Pointer updates only on a grant.
REQ-028 Range check: an address >= 64 causes no mem_write/mem_read in ACESSO and err_addr = 1 during RESPOSTA.
REQ-029 Out-of-range read: rdata = 0 and rvalid is still pulsed.
REQ-030 Out-of-range write: no rvalid is pulsed.
REQ-031 Out-of-range effect on acessos: not incremented.
REQ-032 acessos: increments by 1 on each in-range access, at the edge ending ACESSO; wraps from 0xFFFF to 0.
REQ-033 Unused-port outputs: mem_pos and mem_dados hold their last values outside ACESSO; strobes are 0 outside ACESSO.

Reset
REQ-034 Reset action: when rst_n = 0, the block immediately sets state = OCIOSO and clears all outputs: gnt, rvalid, rdata, err_addr, mem_write, mem_read, mem_pos, mem_dados, acessos.
REQ-035 Reset pointer value: the round-robin pointer resets to "last = 1", so requester 0 wins the first tie.
REQ-036 Reset mid-operation: if reset asserts during ACESSO before the edge, the write is not committed and no rvalid is issued.
REQ-037 Reset release: the first request is sampled on the first clock edge with rst_n = 1.

Structure
REQ-038 Shared include file: holds the state encodings (2-bit), MEM_PALAVRAS = 64 and the acessos width.
REQ-039 Sub-module: the round-robin pick and pointer is a sub-module arb_rr2 (inputs req0, req1, update; output vencedor).
REQ-040 Memory integration: the block connects directly to the existing data memory's write/read/address/data ports without modification.

Verification
REQ-041 Single read: write 0xDEADBEEF to addr 5 via port 0, then read addr 5 via port 1 -> gnt1 at E+1, rvalid1 at E+2, rdata = 0xDEADBEEF, acessos = 2.
REQ-042 Tie: req0 and req1 both high and held continuously -> grants alternate 0,1,0,1; gnt pulses 3 cycles apart.
REQ-043 Out of range: port 0 read at addr 64 -> no mem_read, err_addr pulse, rvalid0 with rdata = 0, acessos unchanged.
REQ-044 Reset mid-write: port 1 writes 0x12345678 to addr 3 and rst_n drops during ACESSO -> memory word 3 unchanged, all outputs 0, first tie after release granted to port 0.
REQ-045 Counter wrap: preload by 65535 accesses -> acessos = 0xFFFF; one more access -> acessos = 0.
REQ-046 Sole requester: only req1 high in back-to-back requests -> every grant goes to port 1, with no starvation from a stale pointer.
